// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader: controller states and
// output-buffer depth.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int OBUF_DEPTH = 3;

endpackage

// File: rtl/fifo_stream_reader_obuf.sv
// Three-entry register FIFO of {last, data} beats. Entry 0 is always the head,
// so a pop shifts the remaining entries down by one.
module stream_obuf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             push_last,
    input  logic [DSIZE-1:0] push_data,
    input  logic             pop,
    output logic [DSIZE-1:0] head_data,
    output logic             head_last,
    output logic [1:0]       occ
);

    typedef struct packed {
        logic             last;
        logic [DSIZE-1:0] data;
    } entry_t;

    entry_t     mem_q [OBUF_DEPTH];
    entry_t     mem_d [OBUF_DEPTH];
    logic [1:0] occ_q, occ_d;
    logic       do_pop;
    logic [1:0] wr_idx;

    // NOTE: every always_comb output gets a default on entry, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mem_d  = mem_q;
        do_pop = pop && (occ_q != 2'd0);
        wr_idx = do_pop ? occ_q - 2'd1 : occ_q;
        if (do_pop) begin
            for (int i = 0; i < OBUF_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[OBUF_DEPTH-1] = '0;
        end
        // A push into a full buffer cannot happen: the reader never has more
        // than OBUF_DEPTH words buffered or in flight.
        if (push && (wr_idx < 2'(OBUF_DEPTH))) begin
            mem_d[wr_idx] = '{last: push_last, data: push_data};
        end
        occ_d = occ_q + 2'(push) - 2'(do_pop);
    end

    // NOTE: the storage is reset along with the pointers because the head
    // entry drives m_data directly and must read as zero out of reset.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign head_data = mem_q[0].data;
    assign head_last = mem_q[0].last;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for a 1-cycle-latency fifo_sync: drains it into a
// valid/ready stream in packets of BURST beats, or shorter when flushed.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int BURST = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic [ASIZE:0]   fifo_rd_count,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             busy,
    output logic             pkt_done
);

    localparam int             CW        = ASIZE + 1;
    localparam int             IW        = $clog2(BURST) + 1;
    localparam logic [CW-1:0]  BURST_CNT = CW'(BURST);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(BURST - 1);

    state_e          state_q, state_d;
    logic            flushing_q, flushing_d;
    logic [IW-1:0]   issue_cnt_q, issue_cnt_d;
    logic            inflight_q, inflight_d;
    logic            last_tag_q, last_tag_d;

    logic [1:0]      occ;
    logic [2:0]      pending;
    logic            rd_en;
    logic            issue_last;
    logic            hs;

    always_comb begin
        state_d     = state_q;
        flushing_d  = flushing_q;
        issue_cnt_d = issue_cnt_q;
        rd_en       = 1'b0;
        pkt_done    = 1'b0;
        hs          = m_valid && m_ready;
        pending     = {1'b0, occ} + {2'b0, inflight_q};
        issue_last  = (issue_cnt_q == LAST_IDX) ||
                      (flushing_q && (fifo_rd_count == CW'(1)));

        case (state_q)
            ST_IDLE: begin
                if (fifo_rd_count >= BURST_CNT) begin
                    state_d     = ST_RUN;
                    flushing_d  = 1'b0;
                    issue_cnt_d = '0;
                end else if (flush && !fifo_empty) begin
                    state_d     = ST_RUN;
                    flushing_d  = 1'b1;
                    issue_cnt_d = '0;
                end
            end
            ST_RUN: begin
                // Reads are throttled on buffered-plus-in-flight words only,
                // keeping m_ready out of the FIFO read path.
                rd_en = !fifo_empty && (pending < 3'(OBUF_DEPTH));
                if (rd_en) begin
                    issue_cnt_d = issue_cnt_q + IW'(1);
                    if (issue_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (hs && m_last) begin
                    state_d  = ST_IDLE;
                    pkt_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        inflight_d = rd_en;
        last_tag_d = rd_en && issue_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            flushing_q  <= 1'b0;
            issue_cnt_q <= '0;
            inflight_q  <= 1'b0;
            last_tag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flushing_q  <= flushing_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            last_tag_q  <= last_tag_d;
        end
    end

    stream_obuf #(
        .DSIZE (DSIZE)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_last (last_tag_q),
        .push_data (fifo_dout),
        .pop       (hs),
        .head_data (m_data),
        .head_last (m_last),
        .occ       (occ)
    );

    assign fifo_rd_en = rd_en;
    assign m_valid    = (occ != 2'd0);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural 1-cycle-latency
// FIFO in front of it and a beat recorder on the stream side.
module tb_fifo_stream_reader;

    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DSIZE-1:0] fifo_dout;
    logic             fifo_empty;
    logic [ASIZE:0]   fifo_rd_count;
    logic             fifo_rd_en;
    logic             flush;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             busy;
    logic             pkt_done;

    fifo_stream_reader #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE),
        .BURST (BURST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_count (fifo_rd_count),
        .fifo_rd_en    (fifo_rd_en),
        .flush         (flush),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .busy          (busy),
        .pkt_done      (pkt_done)
    );

    always #5 clk = ~clk;

    // Behavioural NORMAL-mode FIFO: read data appears the cycle after the strobe.
    logic [DSIZE-1:0] fmem [16];
    logic [3:0]       wp, rp;
    logic [ASIZE:0]   fcnt;
    logic             fifo_clr;
    logic             wr_en;
    logic [DSIZE-1:0] wr_data;

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp        <= '0;
            rp        <= '0;
            fcnt      <= '0;
            fifo_dout <= '0;
        end else begin
            if (wr_en) begin
                fmem[wp] <= wr_data;
                wp       <= wp + 4'd1;
            end
            if (fifo_rd_en && fcnt != '0) begin
                fifo_dout <= fmem[rp];
                rp        <= rp + 4'd1;
            end
            fcnt <= fcnt + 5'(wr_en) - 5'(fifo_rd_en && fcnt != '0);
        end
    end

    assign fifo_empty    = (fcnt == '0);
    assign fifo_rd_count = fcnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream-side recorder, updated once per cycle by tick().
    int          cyc;
    int          n_rd, n_hs, n_done, max_out;
    logic [8:0]  beats [$];
    int          beat_cyc [$];
    logic        prev_stall;
    logic [8:0]  prev_beat;
    logic        busy_seen;

    task automatic clear_mon();
        cyc        = 0;
        n_rd       = 0;
        n_hs       = 0;
        n_done     = 0;
        max_out    = 0;
        prev_stall = 1'b0;
        prev_beat  = '0;
        busy_seen  = 1'b0;
        beats.delete();
        beat_cyc.delete();
    endtask

    // Sample on the falling edge, then step to just after the next rising edge
    // where the caller drives the following cycle's inputs.
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                check("hold", int'({m_valid, m_last, m_data}), int'({1'b1, prev_beat}));
            end
            if (fifo_rd_en) n_rd++;
            if (n_rd - n_hs > max_out) max_out = n_rd - n_hs;
            if (m_valid && m_ready) begin
                beats.push_back({m_last, m_data});
                beat_cyc.push_back(cyc);
                n_hs++;
            end
            if (pkt_done) n_done++;
            if (busy) busy_seen = 1'b1;
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset the DUT and FIFO, then load n words while the DUT is held in reset.
    task automatic start_test(input int n, input int base);
        rst_n    = 1'b0;
        fifo_clr = 1'b1;
        wr_en    = 1'b0;
        flush    = 1'b0;
        m_ready  = 1'b0;
        tick();
        fifo_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = DSIZE'(base + i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        clear_mon();
    endtask

    // Last beat expected on every BURST-th beat and on the final beat.
    task automatic check_beats(input string tag, input int n, input int base);
        check({tag, "_nbeats"}, beats.size(), n);
        for (int i = 0; i < beats.size() && i < n; i++) begin
            check({tag, "_data"}, int'(beats[i][7:0]), base + i);
            check({tag, "_last"}, int'(beats[i][8]),
                  int'(((i % BURST) == BURST - 1) || (i == n - 1)));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        fifo_clr = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        m_ready  = 1'b0;

        // Two full packets back to back, m_ready held high.
        start_test(8, 8'h10);
        check("rst_valid", int'(m_valid), 0);
        check("rst_last", int'(m_last), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rd_en", int'(fifo_rd_en), 0);
        check("rst_pkt_done", int'(pkt_done), 0);
        m_ready = 1'b1;
        rst_n   = 1'b1;
        repeat (20) tick();
        check_beats("t1", 8, 8'h10);
        if (beat_cyc.size() == 8) begin
            check("t1_first_lat", beat_cyc[0], 3);
            check("t1_pkt2_start", beat_cyc[4], 10);
            for (int i = 1; i < 8; i++) begin
                if ((i % BURST) != 0) check("t1_consec", beat_cyc[i], beat_cyc[i-1] + 1);
            end
        end
        check("t1_pkt_done", n_done, 2);
        check("t1_busy_end", int'(busy), 0);

        // Residual data waits for flush; a one-cycle flush pulse stays latched.
        start_test(3, 8'h20);
        m_ready = 1'b1;
        rst_n   = 1'b1;
        repeat (20) tick();
        check("t2_no_beats", beats.size(), 0);
        check("t2_no_busy", int'(busy_seen), 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (10) tick();
        check_beats("t2", 3, 8'h20);
        if (beat_cyc.size() == 3) begin
            check("t2_consec1", beat_cyc[1], beat_cyc[0] + 1);
            check("t2_consec2", beat_cyc[2], beat_cyc[1] + 1);
        end
        check("t2_pkt_done", n_done, 1);
        check("t2_busy_end", int'(busy), 0);
        check("t2_fifo_count", int'(fifo_rd_count), 0);

        // Alternating backpressure: order, hold and outstanding bound.
        start_test(8, 8'h30);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_ready = ((i % 2) == 0);
            tick();
        end
        check_beats("t3", 8, 8'h30);
        check("t3_pkt_done", n_done, 2);
        check("t3_max_out", int'(max_out <= 3), 1);

        // Full backpressure: exactly three reads, then stall.
        start_test(8, 8'h40);
        m_ready = 1'b0;
        rst_n   = 1'b1;
        repeat (10) tick();
        check("t4_reads", n_rd, 3);
        check("t4_fifo_count", int'(fifo_rd_count), 5);
        check("t4_valid", int'(m_valid), 1);
        check("t4_data", int'(m_data), 8'h40);
        check("t4_max_out", max_out, 3);

        // Reset pulse while the second beat is on the bus.
        start_test(8, 8'h50);
        m_ready = 1'b1;
        rst_n   = 1'b1;
        repeat (4) tick();
        check("t5_pre_valid", int'(m_valid), 1);
        check("t5_pre_data", int'(m_data), 8'h51);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_valid", int'(m_valid), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_rd_en", int'(fifo_rd_en), 0);
        check("t5_pkt_done", int'(pkt_done), 0);

        // Flush with a writer keeping pace: BURST limit ends the packet,
        // then a normal packet follows.
        start_test(2, 8'h60);
        m_ready = 1'b1;
        rst_n   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_en   = (i < 6);
            wr_data = DSIZE'(8'h62 + i);
            flush   = (i < 2);
            tick();
        end
        wr_en = 1'b0;
        flush = 1'b0;
        check_beats("t6", 8, 8'h60);
        if (beat_cyc.size() == 8) check("t6_last_cyc", beat_cyc[3], 6);
        check("t6_pkt_done", n_done, 2);
        check("t6_busy_end", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
